// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS EX-stage multiply/divide unit.
package mips_pkg;
  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;
endpackage

// File: rtl/md_addsub.sv
// Ripple add/subtract: sum = x + y, or x - y when sub is set.
module md_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum
);
  logic [W-1:0] yb;
  logic [W-1:0] c;

  assign yb   = y ^ {W{sub}};
  assign c[0] = sub;

  genvar i;
  generate
    for (i = 0; i < W-1; i++) begin : g_fa
      md_fa u_fa (.x(x[i]), .y(yb[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
    end
  endgenerate

  // Carry out of the top bit is never consumed.
  assign sum[W-1] = x[W-1] ^ yb[W-1] ^ c[W-1];
endmodule

// File: rtl/md_fa.sv
// One-bit full-adder cell.
module md_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO ownership; one add/sub step per cycle.
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = MD_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(ITER);

  md_state_e          state, state_n;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     acc, as_x, as_y, as_sum, mul_s;
  logic [WIDTH-1:0]   mq, mcand, abs_a, abs_b, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic               is_div, sign_q, sign_r, commit;
  logic               op_div, op_sgn, sa, sb, launch, dbz;

  assign op_div = (op == OP_DIV) || (op == OP_DIVU);
  assign op_sgn = (op == OP_MULT) || (op == OP_DIV);
  assign sa     = op_sgn & a[WIDTH-1];
  assign sb     = op_sgn & b[WIDTH-1];
  assign abs_a  = sa ? -a : a;
  assign abs_b  = sb ? -b : b;
  assign launch = start && (state == S_IDLE);
  assign dbz    = launch && op_div && (b == '0);

  // Divide feeds the left-shifted remainder; multiply feeds the accumulator.
  assign as_x = is_div ? {acc[WIDTH-1:0], mq[WIDTH-1]} : acc;
  assign as_y = {1'b0, mcand};

  md_addsub #(.W(WIDTH+1)) u_addsub (
    .x   (as_x),
    .y   (as_y),
    .sub (is_div),
    .sum (as_sum)
  );

  assign mul_s    = mq[0] ? as_sum : acc;
  assign prod     = {acc[WIDTH-1:0], mq};
  assign prod_fix = sign_q ? -prod : prod;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (launch && !dbz) state_n = S_RUN;
      S_RUN:   if (count == CW'(ITER-1)) state_n = S_FIX;
      S_FIX:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      commit      <= 1'b0;
      count       <= '0;
      acc         <= '0;
      mq          <= '0;
      mcand       <= '0;
      is_div      <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      res_hi      <= '0;
      res_lo      <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      commit      <= 1'b0;
      // busy trails the state by one edge so it drops exactly as HI/LO load
      busy        <= (state != S_IDLE);
      if (commit) begin
        hi   <= res_hi;
        lo   <= res_lo;
        done <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (dbz) begin
            done        <= 1'b1;
            div_by_zero <= 1'b1;
          end else if (launch) begin
            is_div <= op_div;
            mcand  <= op_div ? abs_b : abs_a;
            mq     <= op_div ? abs_a : abs_b;
            acc    <= '0;
            sign_q <= sa ^ sb;
            sign_r <= sa;
            count  <= '0;
          end
        end
        S_RUN: begin
          count <= count + CW'(1);
          if (is_div) begin
            acc <= as_sum[WIDTH] ? as_x : as_sum;
            mq  <= {mq[WIDTH-2:0], ~as_sum[WIDTH]};
          end else begin
            acc <= {1'b0, mul_s[WIDTH:1]};
            mq  <= {mul_s[0], mq[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          commit <= 1'b1;
          if (is_div) begin
            res_lo <= sign_q ? -mq : mq;
            res_hi <= sign_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          end else begin
            {res_hi, res_lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a cycle-level reference model.
module tb_mul_div_unit;
  import mips_pkg::*;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: returns {hi, lo}; division truncates toward zero.
  function automatic logic [63:0] md_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      2'b00: p = sx * sy;
      2'b01: p = {32'b0, x} * {32'b0, y};
      2'b10: begin q = sx / sy; r = sx % sy; p = {r[31:0], q[31:0]}; end
      default: p = {x % y, x / y};
    endcase
    return p;
  endfunction

  // Timeline model: ph counts edges since launch (1 = launch edge, 0 = idle).
  int          ph = 0;
  logic        m_busy = 0, m_done = 0, m_dbz = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_res = 0;

  always @(posedge clk) begin
    if (reset) begin
      ph = 0; m_busy = 0; m_done = 0; m_dbz = 0; m_hi = 0; m_lo = 0;
    end else begin
      m_done = 0; m_dbz = 0;
      if (ph != 0) ph++;
      m_busy = (ph >= 2 && ph <= 34);
      if (ph == 35) begin
        {m_hi, m_lo} = m_res; m_done = 1; ph = 0;
      end
      if (start && ph == 0) begin
        if (op[1] && b == 32'd0) begin m_done = 1; m_dbz = 1; end
        else begin m_res = md_model(op, a, b); ph = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", busy, m_busy);
      chk("cyc_done", done, m_done);
      chk("cyc_dbz", div_by_zero, m_dbz);
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  // Drives a one-cycle start and waits (bounded) for done; returns at the done negedge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcy);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 1; bcy = 0;
    while (!done && n < 60) begin
      if (busy) bcy++;
      @(negedge clk);
      n++;
    end
    lat = n - 1;
    if (!done) begin
      errors++; checks++;
      $display("FAIL done_timeout got no done want done op=%0d", o);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat, bcy;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);

    // Pin the reference model against hand values.
    chk("model_mult", md_model(OP_MULT, 32'd7, 32'hFFFFFFFD), 64'hFFFFFFFF_FFFFFFEB);
    chk("model_div", md_model(OP_DIV, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    // 1
    run_op(OP_MULT, 32'd7, 32'hFFFFFFFD, lat, bcy);
    chk("t1_lat", lat, 34);
    chk("t1_busy_cycles", bcy, 33);
    chk("t1_hi", hi, 32'hFFFFFFFF);
    chk("t1_lo", lo, 32'hFFFFFFEB);
    // 2 (back-to-back: each start is issued in the done cycle)
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcy);
    chk("t2_lat_b2b", lat, 34);
    chk("t2u_hi", hi, 32'hFFFFFFFE);
    chk("t2u_lo", lo, 32'h00000001);
    run_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcy);
    chk("t2s_hi", hi, 32'h0);
    chk("t2s_lo", lo, 32'h1);
    run_op(OP_MULT, 32'h80000000, 32'h80000000, lat, bcy);
    chk("ovf_mult_hi", hi, 32'h40000000);
    chk("ovf_mult_lo", lo, 32'h0);
    // 3
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bcy);
    chk("t3a_lo", lo, 32'hFFFFFFFD);
    chk("t3a_hi", hi, 32'hFFFFFFFF);
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bcy);
    chk("t3b_lo", lo, 32'd14);
    chk("t3b_hi", hi, 32'd2);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcy);
    chk("t3c_lo", lo, 32'h80000000);
    chk("t3c_hi", hi, 32'h0);
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, lat, bcy);
    chk("t3d_lo", lo, 32'hFFFFFFFD);
    chk("t3d_hi", hi, 32'd1);
    // 4: preload hi=0x11 lo=0x22, then divide by zero
    run_op(OP_DIVU, 32'h2211, 32'h100, lat, bcy);
    run_op(OP_DIVU, 32'd5, 32'd0, lat, bcy);
    chk("t4_lat", lat, 0);
    chk("t4_dbz", div_by_zero, 1);
    chk("t4_hi", hi, 32'h11);
    chk("t4_lo", lo, 32'h22);
    chk("t4_busy_cycles", bcy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_busy_after", busy, 0);
      chk("t4_done_after", done, 0);
    end
    // 5: second start during RUN is ignored
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 60 && !done; n++) @(negedge clk);
    chk("t5_done", done, 1);
    chk("t5_hi", hi, 32'h0);
    chk("t5_lo", lo, 32'd12);
    // 6: reset mid-RUN
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_hi", hi, 32'h0);
    chk("t6_lo", lo, 32'h0);
    repeat (25) begin
      @(negedge clk);
      chk("t6_no_done", done, 0);
    end
    run_op(OP_MULT, 32'd2, 32'd3, lat, bcy);
    chk("t6_mult_lo", lo, 32'd6);
    chk("t6_mult_hi", hi, 32'd0);
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath; implements MULT, MULTU, DIV, DIVU and owns the HI/LO registers.
- Sits beside the ALU in EX.
- Operands come from the register-file read ports. Results are read by MFHI/MFLO through the hi/lo outputs.
- One 33-bit add/subtract step per cycle: shift-add for multiply, restoring shift-subtract for divide.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  launch request; sampled on the rising edge.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse in the cycle HI/LO first show the new result.
- div_by_zero  output  1  one-cycle pulse together with done for DIV/DIVU when b==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Interface decision: one clock; reset is synchronous and active-high (clk, reset).

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - Reset during any state aborts the operation immediately, with the same values.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 captures a, b and op.
  - Signed ops take |a| and |b|, and record sign_q = a[31]^b[31] and sign_r = a[31].
  - Go to RUN with count=0.
- Divide by zero (DIV/DIVU with b==0):
  - Stay in IDLE.
  - Next cycle: done=1, div_by_zero=1; hi/lo unchanged.
- RUN, one step per cycle, count increments; after count reaches ITER-1, go to FIX.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the 33-bit upper accumulator. Then shift {acc, multiplier} right by 1.
  - Divide: shift {rem, quotient} left by 1; trial = rem - divisor (33-bit). If trial is non-negative, rem = trial and quotient LSB = 1; otherwise restore.
- FIX (one cycle): apply the sign correction and go to IDLE. On the next edge:
  - hi/lo load the final value, done=1 for exactly one cycle, busy=0.
  - Multiply: negate the 64-bit product if sign_q (signed ops only).
  - Divide: quotient negated if sign_q → LO; remainder negated if sign_r → HI. Truncation is toward zero.
- Latency: start sampled at edge k; busy=1 during cycles k+1..k+33; hi/lo updated and done=1 at edge k+34.
- Back-to-back: a new start is accepted in the same cycle as done, since the state is IDLE.
- start while busy is ignored: no capture, no state change.
- hi/lo only change on done (or reset); they hold their value during RUN so MFHI/MFLO of the old result remains valid.
- Overflow cases:
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. This is the natural magnitude result; no trap.
  - MULT −2^31 × −2^31 → HI=0x40000000, LO=0.
- Width rules:
  - Accumulator and remainder are 33 bits to hold the carry/borrow.
  - Magnitude of 0x80000000 is 2^31 and must be represented correctly in 32 unsigned bits.

Decomposition:
- Shared package (mips_pkg):
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
  - state encodings S_IDLE/S_RUN/S_FIX.
  - MD_ITER=32.
- Sub-module md_addsub:
  - 33-bit ripple add/subtract built from the team's full-adder cell.
  - Inputs x, y, sub; outputs sum[32:0].
  - Used for both the accumulate and trial-subtract steps.
  - Negation in FIX uses the same unit or a plain two's-complement.

Test Plan:
1. MULT a=7, b=0xFFFFFFFD (−3) → after 34 cycles: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
2. MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; MULT of the same operands → hi=0, lo=1.
3. DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU a=5, b=0 with hi/lo preloaded 0x11/0x22 → one cycle later done=1, div_by_zero=1, hi=0x11, lo=0x22, busy never set.
5. Robustness:
   - start MULTU 3×4, then pulse start with DIVU 9/3 at cycle k+10 → second start ignored, result hi=0, lo=12.
   - A new start in the done cycle is accepted.
6. Reset mid-RUN:
   - Assert reset at cycle k+15 → next cycle busy=0, hi=lo=0, no done pulse.
   - A subsequent MULT 2×3 gives lo=6.
